// File: rtl/booth_pkg.sv
// ============================================================================
// booth_pkg : shared FSM state and radix-4 recode op constants
// Revision  : 1.0
// ============================================================================
`default_nettype none

package booth_pkg;

  localparam int unsigned ST_W = 2;
  localparam logic [ST_W-1:0] ST_IDLE = 2'b00;
  localparam logic [ST_W-1:0] ST_RUN  = 2'b01;
  localparam logic [ST_W-1:0] ST_DONE = 2'b10;

  localparam int unsigned OP_W = 3;
  localparam logic [OP_W-1:0] OP_ZERO = 3'd0;
  localparam logic [OP_W-1:0] OP_PA   = 3'd1;
  localparam logic [OP_W-1:0] OP_P2A  = 3'd2;
  localparam logic [OP_W-1:0] OP_MA   = 3'd3;
  localparam logic [OP_W-1:0] OP_M2A  = 3'd4;

endpackage

`default_nettype wire

// File: rtl/booth_r4_recoder.sv
// ============================================================================
// booth_r4_recoder : maps a Booth triple {b1, b0, q(-1)} to a recode op
// Revision         : 1.0
// ============================================================================
`default_nettype none

module booth_r4_recoder
  import booth_pkg::*;
(
  input  logic [2:0]      triple_i,
  output logic [OP_W-1:0] op_o
);

  always_comb begin
    op_o = OP_ZERO;
    case (triple_i)
      3'b001, 3'b010: op_o = OP_PA;
      3'b011:         op_o = OP_P2A;
      3'b100:         op_o = OP_M2A;
      3'b101, 3'b110: op_o = OP_MA;
      default:        op_o = OP_ZERO;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/booth_mul_r4.sv
// ============================================================================
// booth_mul_r4 : sequential radix-4 Booth multiplier, signed/unsigned per op
// Revision     : 1.0
// ============================================================================
`default_nettype none

module booth_mul_r4
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned N     = WIDTH + 2;
  localparam int unsigned XW    = N + 2;
  localparam int unsigned CNT_W = $clog2(N/2 + 1);
  localparam logic [CNT_W-1:0] C_ITER = CNT_W'(N/2);
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

  logic [ST_W-1:0]    state_q, state_d;
  logic [N-1:0]       a_q, a_d;
  logic [N-1:0]       b_q, b_d;
  logic [XW-1:0]      x_q, x_d;
  logic               qm1_q, qm1_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  logic [OP_W-1:0]    w_op;
  logic [XW-1:0]      w_a_ext;
  logic [XW-1:0]      w_a2;
  logic [XW-1:0]      w_addend;
  logic [XW-1:0]      w_sum;
  logic [XW-1:0]      w_x_sh;
  logic [N-1:0]       w_b_sh;

  booth_r4_recoder u_recoder (
    .triple_i ({b_q[1], b_q[0], qm1_q}),
    .op_o     (w_op)
  );

  assign w_a_ext = {{2{a_q[N-1]}}, a_q};
  assign w_a2    = {a_q[N-1], a_q, 1'b0};

  always_comb begin
    w_addend = '0;
    case (w_op)
      OP_PA:   w_addend = w_a_ext;
      OP_P2A:  w_addend = w_a2;
      OP_MA:   w_addend = -w_a_ext;
      OP_M2A:  w_addend = -w_a2;
      default: w_addend = '0;
    endcase
  end

  // {X,B,q(-1)} shifted right by two, sign-filled from the new X MSB
  assign w_sum  = x_q + w_addend;
  assign w_x_sh = {{2{w_sum[XW-1]}}, w_sum[XW-1:2]};
  assign w_b_sh = {w_sum[1:0], b_q[N-1:2]};

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    x_d       = x_q;
    qm1_d     = qm1_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = {{2{signed_mode & in1[WIDTH-1]}}, in1};
          b_d     = {{2{signed_mode & in2[WIDTH-1]}}, in2};
          x_d     = '0;
          qm1_d   = 1'b0;
          cnt_d   = C_ITER;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        x_d   = w_x_sh;
        b_d   = w_b_sh;
        qm1_d = b_q[1];
        cnt_d = cnt_q - C_ONE;
        if (cnt_q == C_ONE) begin
          product_d = {w_x_sh[2*WIDTH-N-1:0], w_b_sh};
          state_d   = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      x_q       <= '0;
      qm1_q     <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      x_q       <= x_d;
      qm1_q     <= qm1_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_DONE);
  assign product = product_q;

endmodule

`default_nettype wire

// File: tb/tb_booth_mul_r4.sv
// ============================================================================
// tb_booth_mul_r4 : directed + randomised checks of booth_mul_r4 (WIDTH=8)
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_booth_mul_r4;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned LAT   = WIDTH/2 + 1;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic               signed_mode = 1'b0;
  logic [WIDTH-1:0]   in1 = '0;
  logic [WIDTH-1:0]   in2 = '0;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  int n_total = 0;
  int n_bad   = 0;
  int n_done  = 0;
  logic [2*WIDTH-1:0] last_prod = '0;

  booth_mul_r4 #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .signed_mode (signed_mode),
    .in1         (in1),
    .in2         (in2),
    .busy        (busy),
    .done        (done),
    .product     (product)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) n_done++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2*WIDTH-1:0] ref_mul(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic sm);
    longint pa, pb, p;
    pa = sm ? longint'($signed(a)) : longint'({56'd0, a});
    pb = sm ? longint'($signed(b)) : longint'({56'd0, b});
    p  = pa * pb;
    return p[2*WIDTH-1:0];
  endfunction

  // Called #1 after the start edge; returns cycles until done, product held meanwhile
  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 1; i <= 3*LAT && lat == 0; i++) begin
      @(posedge clk); #1;
      if (done) lat = i;
      else chk_eq("hold", 32'(product), 32'(last_prod));
    end
  endtask

  task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic sm, input string tag);
    int lat;
    logic [2*WIDTH-1:0] exp_p;
    exp_p = ref_mul(a, b, sm);
    @(negedge clk);
    in1 = a; in2 = b; signed_mode = sm; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    in1 = WIDTH'($urandom); in2 = WIDTH'($urandom); signed_mode = 1'($urandom);
    chk_eq({tag, "_busy"}, 32'(busy), 32'd1);
    wait_done(lat);
    chk_eq({tag, "_lat"}, lat, LAT);
    chk_eq({tag, "_prod"}, 32'(product), 32'(exp_p));
    last_prod = exp_p;
    @(posedge clk); #1;
    chk_eq({tag, "_done_off"}, 32'(done), 32'd0);
    chk_eq({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int lat;
    int base;
    #12;
    chk_eq("rst_prod", 32'(product), 32'd0);
    chk_eq("rst_busy", 32'(busy), 32'd0);
    chk_eq("rst_done", 32'(done), 32'd0);
    @(negedge clk); rst = 1'b0;

    do_op(8'h80, 8'h80, 1'b1, "s_m128sq");
    do_op(8'hFF, 8'hFF, 1'b0, "u_255sq");
    do_op(8'hFF, 8'hFF, 1'b1, "s_m1sq");
    do_op(8'h7F, 8'h80, 1'b1, "s_127xm128");
    do_op(8'hFF, 8'h01, 1'b1, "s_m1x1");

    // start held high: second op accepted only from IDLE after DONE
    base = n_done;
    @(negedge clk);
    in1 = 8'd3; in2 = 8'd5; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    wait_done(lat);
    chk_eq("hs_lat1", lat, LAT);
    chk_eq("hs_prod1", 32'(product), 32'd15);
    last_prod = 16'd15;
    @(posedge clk); #1;
    chk_eq("hs_idle", 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk_eq("hs_restart", 32'(busy), 32'd1);
    start = 1'b0; in1 = 8'd9; in2 = 8'd9;
    wait_done(lat);
    chk_eq("hs_lat2", lat, LAT);
    chk_eq("hs_prod2", 32'(product), 32'd15);
    @(posedge clk); #1;
    chk_eq("hs_pulses", n_done - base, 2);

    // reset mid-run aborts without writing a partial product
    do_op(8'd2, 8'd3, 1'b0, "pre_rst");
    @(negedge clk);
    in1 = 8'd100; in2 = 8'd100; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b1; #1;
    chk_eq("mr_prod", 32'(product), 32'd0);
    chk_eq("mr_busy", 32'(busy), 32'd0);
    chk_eq("mr_done", 32'(done), 32'd0);
    @(negedge clk); rst = 1'b0;
    last_prod = '0;
    do_op(8'd6, 8'd7, 1'b0, "post_rst");

    for (int k = 0; k < 1000; k++) begin
      do_op(WIDTH'($urandom), WIDTH'($urandom), 1'(k & 1), "rand");
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/booth_mul_r4.md
# booth_mul_r4

Parametrised radix-4 Booth sequential multiplier with an integrated controller and start/done handshake, replacing the radix-2 datapath that relied on an external state driver. It multiplies two WIDTH-bit operands as signed or unsigned, selected per operation, in WIDTH/2+1 iteration cycles. It sits beside the ALU as a multi-cycle functional unit; the result is held until the next accepted start.

## Interface
- WIDTH, 8, operand width; must be even and ≥ 4.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
- in1  in  WIDTH  multiplicand; sampled with start.
- in2  in  WIDTH  multiplier; sampled with start.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse; high only in DONE.
- product  out  2*WIDTH  registered result of the last completed operation.

## Operation
- States: IDLE, RUN, DONE. Encoding is 2 bits, from the shared package.
- IDLE, start=1: load internal registers.
  - Multiplicand A = in1 extended to N = WIDTH+2 bits: sign-extended if signed_mode, zero-extended otherwise.
  - Multiplier register B = in2, extended the same way.
  - Accumulator X = 0; implicit bit q(-1) = 0.
  - Iteration counter = N/2.
  - Next state RUN.
- IDLE, start=0: hold all state.
- RUN, each cycle:
  - Recode the triple {B[1], B[0], q(-1)} into an op: 000/111 → 0; 001/010 → +A; 011 → +2A; 100 → −2A; 101/110 → −A.
  - Apply the op to X. X is N+2 bits wide, so ±2A never overflows.
  - Arithmetic-shift {X,B,q(-1)} right by 2, sign-filling from the X MSB.
  - Decrement the counter.
- RUN, counter reaching 0 on this edge:
  - Write product = low 2*WIDTH bits of {X,B} after the final shift. The result is exact in both modes.
  - Next state DONE.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- start is ignored while busy=1; no queuing.
- signed_mode, in1 and in2 may change freely after the sampling edge.
- product changes only on the RUN→DONE edge and on reset.

## Timing
- Reset values: state IDLE, busy=0, done=0, product=0, and all internal registers 0.
- Reset mid-RUN aborts immediately, with no partial product written.
- Edge 0 is the edge that samples start in IDLE.
  - Iterations execute on edges 1..N/2.
  - done is high in the cycle following edge N/2+... precisely, in the cycle following edge WIDTH/2+1.
  - For WIDTH=8, done is high between edges 5 and 6.
- busy rises after edge 0 and falls after the DONE cycle.
- Fastest back-to-back rate: a new start is accepted on the edge after DONE (IDLE cycle). Throughput is one result per WIDTH/2+3 cycles.
- The done pulse and the new product value are visible in the same cycle.

## Structure
- Shared package booth_pkg:
  - State constants ST_IDLE=2'b00, ST_RUN=2'b01, ST_DONE=2'b10.
  - Recode op constants OP_ZERO, OP_PA, OP_P2A, OP_MA, OP_M2A.
- Sub-module booth_r4_recoder: combinational, 3-bit triple in, op code out. It is the single point of recode truth and is reused by future pipelined variants.
- The top module holds the FSM, counter, datapath registers and product register.

## Test plan
All scenarios use WIDTH=8.
- Signed: in1=−128, in2=−128, signed_mode=1 → product=0x4000. done pulses exactly once, 5 cycles after the start edge.
- Unsigned: in1=255, in2=255, signed_mode=0 → product=0xFE01. The same operands with signed_mode=1 → product=0x0001.
- Signed: in1=127, in2=−128 → product=0xC080. in1=−1, in2=1 → product=0xFFFF.
- start held high throughout an operation (3, 5):
  - product=15 after the first done.
  - Second operation starts only from IDLE after DONE.
  - No spurious done.
- After a completed operation, rst asserted in RUN mid-way through a second operation:
  - product=0, busy=0, done=0 immediately.
  - A subsequent start (6, 7) yields 42 with normal latency.
- Randomised 1000 operands in both modes against a reference product, checking exactness and that product is stable between done pulses.
